// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared RV32I register file constants and helpers
// Contents: DEFAULT_XLEN (default data width), REG_ZERO (hardwired zero
// register index), slice_base() (base bit of lane 'port' in a packed bus
// made of lanes that are each 'width' bits wide).
package rv_pkg;

    localparam int DEFAULT_XLEN = 32;
    localparam int REG_ZERO     = 0;

    function automatic int slice_base(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_busy_table.sv
// rtl/regfile_busy_table.sv - per-register busy scoreboard with claim/release/flush
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   we, wa                   writeback releases busy[wa]
//   claim, claim_addr        long-latency issue sets busy[claim_addr]
//   flush                    clears every busy bit
//   ra                       packed read addresses, one AW lane per port
//   busy_lookup              next-state busy bit for each read address
//   any_busy                 OR of the stored busy bits
module regfile_busy_table
    import rv_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic              claim,
    input  logic [AW-1:0]     claim_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD-1:0]    busy_lookup,
    output logic              any_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wr_live;
    logic            claim_live;

    assign wr_live    = we    && !((ZERO_REG != 0) && (wa == AW'(REG_ZERO)));
    assign claim_live = claim && !((ZERO_REG != 0) && (claim_addr == AW'(REG_ZERO)));

    // Order matters: flush, then release, then claim. A claim belongs to a
    // newer op than either the squash or the completing write, so it wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        if (wr_live) begin
            busy_d[wa] = 1'b0;
        end
        if (claim_live) begin
            busy_d[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Readers see the post-edge state so a claim or release is visible on
    // rd_busy at the very edge it is applied.
    always_comb begin
        busy_lookup = '0;
        for (int k = 0; k < NRD; k++) begin
            busy_lookup[k] = busy_d[ra[slice_base(k, AW) +: AW]];
        end
    end

    assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - N-read/1-write register file with bypass and busy scoreboard
// Ports:
//   clock, reset             rising-edge clock, async active-high reset
//   rd_en                    advance read registers; 0 holds rd/rd_busy
//   ra, rd, rd_busy          packed read addresses, registered data and busy
//   we, wa, wd               write port
//   claim, claim_addr        mark a register busy for a long-latency op
//   flush                    clear all busy bits
//   any_busy                 OR of stored busy bits
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int NREG     = 32,
    parameter int AW       = $clog2(NREG),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rd_en,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                claim,
    input  logic [AW-1:0]       claim_addr,
    input  logic                flush,
    output logic                any_busy
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [XLEN-1:0] mem_d [NREG];
    logic [NRD-1:0]  busy_lookup;
    logic            wr_live;

    assign wr_live = we && !((ZERO_REG != 0) && (wa == AW'(REG_ZERO)));

    always_comb begin
        mem_d = mem_q;
        if (wr_live) begin
            mem_d[wa] = wd;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_busy_table #(
        .NREG     (NREG),
        .AW       (AW),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clock       (clock),
        .reset       (reset),
        .we          (we),
        .wa          (wa),
        .claim       (claim),
        .claim_addr  (claim_addr),
        .flush       (flush),
        .ra          (ra),
        .busy_lookup (busy_lookup),
        .any_busy    (any_busy)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rd_d;
        logic [XLEN-1:0] rd_q;
        logic            rbusy_d;
        logic            rbusy_q;

        assign addr = ra[slice_base(k, AW) +: AW];

        always_comb begin
            rd_d    = rd_q;
            rbusy_d = rbusy_q;
            if (rd_en) begin
                if ((ZERO_REG != 0) && (addr == AW'(REG_ZERO))) begin
                    rd_d = '0;
                end else if ((BYPASS != 0) && we && (wa == addr)) begin
                    rd_d = wd;
                end else begin
                    rd_d = mem_q[addr];
                end
                rbusy_d = busy_lookup[k];
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rd_q    <= '0;
                rbusy_q <= 1'b0;
            end else begin
                rd_q    <= rd_d;
                rbusy_q <= rbusy_d;
            end
        end

        assign rd[slice_base(k, XLEN) +: XLEN] = rd_q;
        assign rd_busy[k]                      = rbusy_q;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed bench for regfile_scoreboard
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en = 1'b0;
    logic [9:0]  ra = '0;
    logic        we = 1'b0;
    logic [4:0]  wa = '0;
    logic [31:0] wd = '0;
    logic        claim = 1'b0;
    logic [4:0]  claim_addr = '0;
    logic        flush = 1'b0;

    logic [63:0] rd_b, rd_n;
    logic [1:0]  busy_b, busy_n;
    logic        any_b, any_n;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_scoreboard #(.BYPASS(1)) dut (
        .clock(clock), .reset(reset), .rd_en(rd_en), .ra(ra), .rd(rd_b),
        .rd_busy(busy_b), .we(we), .wa(wa), .wd(wd), .claim(claim),
        .claim_addr(claim_addr), .flush(flush), .any_busy(any_b)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset), .rd_en(rd_en), .ra(ra), .rd(rd_n),
        .rd_busy(busy_n), .we(we), .wa(wa), .wd(wd), .claim(claim),
        .claim_addr(claim_addr), .flush(flush), .any_busy(any_n)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if (rd_b !== 64'h0) begin errors++; $display("FAIL reset_rd got %h exp %h", rd_b, 64'h0); end
        checks++;
        if ({busy_b, any_b} !== 3'b000) begin errors++; $display("FAIL reset_busy got %b exp %b", {busy_b, any_b}, 3'b000); end
        reset = 1'b0;
        rd_en = 1'b1;
        ra = {5'd0, 5'd5};
        step();
        checks++;
        if (rd_b !== 64'h0) begin errors++; $display("FAIL read_after_reset got %h exp %h", rd_b, 64'h0); end
        checks++;
        if ({busy_b, any_b} !== 3'b000) begin errors++; $display("FAIL busy_after_reset got %b exp %b", {busy_b, any_b}, 3'b000); end
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 5'd7; wd = 32'hDEADBEEF; ra = {5'd7, 5'd7};
        step();
        checks++;
        if (rd_b !== {32'hDEADBEEF, 32'hDEADBEEF}) begin errors++; $display("FAIL bypass_on got %h exp %h", rd_b, {32'hDEADBEEF, 32'hDEADBEEF}); end
        checks++;
        if (rd_n[31:0] !== 32'h0) begin errors++; $display("FAIL bypass_off_same got %h exp %h", rd_n[31:0], 32'h0); end
        we = 1'b0;
        step();
        checks++;
        if (rd_b[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_on_next got %h exp %h", rd_b[31:0], 32'hDEADBEEF); end
        checks++;
        if (rd_n[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_off_next got %h exp %h", rd_n[31:0], 32'hDEADBEEF); end
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wa = 5'd0; wd = 32'h12345678;
        claim = 1'b1; claim_addr = 5'd0; ra = {5'd0, 5'd0};
        step();
        checks++;
        if (rd_b !== 64'h0) begin errors++; $display("FAIL zero_same got %h exp %h", rd_b, 64'h0); end
        we = 1'b0; claim = 1'b0;
        step();
        checks++;
        if (rd_b !== 64'h0) begin errors++; $display("FAIL zero_read got %h exp %h", rd_b, 64'h0); end
        checks++;
        if ({busy_b, any_b} !== 3'b000) begin errors++; $display("FAIL zero_busy got %b exp %b", {busy_b, any_b}, 3'b000); end
    endtask

    task automatic test_claim_release();
        claim = 1'b1; claim_addr = 5'd3; ra = {5'd3, 5'd3};
        step();
        checks++;
        if ({busy_b, any_b} !== 3'b111) begin errors++; $display("FAIL claim_edge got %b exp %b", {busy_b, any_b}, 3'b111); end
        claim = 1'b0;
        step();
        checks++;
        if (busy_b[0] !== 1'b1) begin errors++; $display("FAIL claim_read got %b exp %b", busy_b[0], 1'b1); end
        step();
        checks++;
        if (any_b !== 1'b1) begin errors++; $display("FAIL claim_any_hold got %b exp %b", any_b, 1'b1); end
        we = 1'b1; wa = 5'd3; wd = 32'h000000A5;
        step();
        we = 1'b0;
        checks++;
        if (rd_b[31:0] !== 32'hA5) begin errors++; $display("FAIL release_data got %h exp %h", rd_b[31:0], 32'hA5); end
        checks++;
        if ({busy_b, any_b} !== 3'b000) begin errors++; $display("FAIL release_busy got %b exp %b", {busy_b, any_b}, 3'b000); end
    endtask

    task automatic test_claim_write_flush();
        claim = 1'b1; claim_addr = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h55; ra = {5'd9, 5'd9};
        step();
        checks++;
        if (rd_b !== {32'h55, 32'h55}) begin errors++; $display("FAIL claim_write_data got %h exp %h", rd_b, {32'h55, 32'h55}); end
        checks++;
        if ({busy_b, any_b} !== 3'b111) begin errors++; $display("FAIL claim_write_busy got %b exp %b", {busy_b, any_b}, 3'b111); end
        we = 1'b0; flush = 1'b1; claim_addr = 5'd4; ra = {5'd9, 5'd4};
        step();
        checks++;
        if (busy_b !== 2'b01) begin errors++; $display("FAIL flush_claim_busy got %b exp %b", busy_b, 2'b01); end
        flush = 1'b0; claim = 1'b0;
        step();
        checks++;
        if ({busy_b, any_b} !== 3'b011) begin errors++; $display("FAIL flush_any got %b exp %b", {busy_b, any_b}, 3'b011); end
    endtask

    task automatic test_hold_and_reset();
        rd_en = 1'b0; we = 1'b1; wa = 5'd2; wd = 32'h77; ra = {5'd2, 5'd2};
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rd_b !== {32'h55, 32'h0}) begin errors++; $display("FAIL hold_rd cycle %0d got %h exp %h", i, rd_b, {32'h55, 32'h0}); end
            checks++;
            if (busy_b !== 2'b01) begin errors++; $display("FAIL hold_busy cycle %0d got %b exp %b", i, busy_b, 2'b01); end
        end
        rd_en = 1'b1; we = 1'b0;
        step();
        checks++;
        if (rd_b !== {32'h77, 32'h77}) begin errors++; $display("FAIL held_write got %h exp %h", rd_b, {32'h77, 32'h77}); end
        checks++;
        if ({busy_b, any_b} !== 3'b001) begin errors++; $display("FAIL held_busy got %b exp %b", {busy_b, any_b}, 3'b001); end
        claim = 1'b1; claim_addr = 5'd5;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({rd_b, rd_n} !== 128'h0) begin errors++; $display("FAIL async_reset_rd got %h exp %h", {rd_b, rd_n}, 128'h0); end
        checks++;
        if ({busy_b, any_b, busy_n, any_n} !== 6'b0) begin errors++; $display("FAIL async_reset_busy got %b exp %b", {busy_b, any_b, busy_n, any_n}, 6'b0); end
        step();
        reset = 1'b0; claim = 1'b0;
        step();
        checks++;
        if (rd_b !== 64'h0) begin errors++; $display("FAIL post_reset_x2 got %h exp %h", rd_b, 64'h0); end
        checks++;
        if ({busy_b, any_b} !== 3'b000) begin errors++; $display("FAIL post_reset_busy got %b exp %b", {busy_b, any_b}, 3'b000); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_claim_release();
        test_claim_write_flush();
        test_hold_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file for the RISCV32I pipeline with N registered read ports, one write port, write-to-read bypass, an optional hardwired zero register and a per-register busy scoreboard. The scoreboard tracks long-latency writes (loads, multi-cycle ops). It sits between decode (reads, claims) and writeback (writes), and replaces the fixed 2-read/1-write file.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREG, 32, number of registers (power of two, ≥2)
- AW, $clog2(NREG), register address width
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and claims
- BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- rd_en  in  1  read-port advance; 0 = read outputs hold
- ra  in  NRD*AW  read addresses; port k at [k*AW +: AW]
- rd  out  NRD*XLEN  read data, registered; port k at [k*XLEN +: XLEN]
- rd_busy  out  NRD  registered busy flag per read port
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- claim  in  1  mark register claim_addr busy (long-latency op issued)
- claim_addr  in  AW  register being claimed
- flush  in  1  clear all busy bits (pipeline squash)
- any_busy  out  1  OR of all busy bits, registered state

## Operation
- Storage: NREG x XLEN array plus NREG busy bits.
- Write: we=1 at a rising edge stores wd into reg[wa] and clears busy[wa]. With ZERO_REG=1 and wa=0, the write is dropped; reg0 stays 0.
- Claim: claim=1 sets busy[claim_addr]. It is ignored for address 0 when ZERO_REG=1.
- Same edge, claim and write to the same address: data is written and busy ends set (the claim wins; it belongs to a newer op).
- flush=1 clears every busy bit. A claim in the same cycle is applied after the flush, so that bit ends set. A write in the same cycle stores normally.
- Read, rd_en=1: rd[k] loads the value of reg[ra[k]] at the edge.
  - If BYPASS=1, we=1 and wa==ra[k] (and not zero-masked), rd[k] loads wd.
  - With ZERO_REG=1 and ra[k]=0, rd[k] loads 0.
- rd_busy[k] loads the next-state busy bit of ra[k], i.e. after this edge's write, claim and flush are applied. This holds regardless of BYPASS.
- Read, rd_en=0: rd and rd_busy hold their values. Writes, claims and flush still take effect.
- Multiple ports may read the same address; all receive identical data.

## Timing
- Read latency is 1 cycle: address presented in cycle n gives data on rd in cycle n+1.
- Write-to-read:
  - BYPASS=1: 0 extra cycles; a read in the same cycle sees the new data.
  - BYPASS=0: a read in the same cycle returns the old value; a read in the next cycle returns the new value.
- Claim/release is visible on rd_busy at the same edge it is applied.
- any_busy reflects stored busy bits; it updates 1 cycle after claim, write or flush.
- Reset (asynchronous, at any time, including mid-read or mid-claim):
  - all registers = 0, all busy = 0
  - rd = 0, rd_busy = 0, any_busy = 0
  - the first edge after reset deassertion behaves normally.

## Structure
- Shared package rv_pkg:
  - XLEN default
  - REG_ZERO constant (0)
  - function for the per-port slice base index
- One natural sub-module, regfile_busy_table:
  - NREG busy bits
  - claim/release/flush priority logic
  - next-state lookup per read port
  - any_busy
- Data array, read registers and bypass muxes stay in regfile_scoreboard, generated per port with a loop over NRD.

## Test plan
- Reset then read ports 0..1 at addresses 5 and 0 -> rd = 0, 0; rd_busy = 00; any_busy = 0.
- Write 0xDEADBEEF to x7 with a read of x7 in the same cycle -> rd = 0xDEADBEEF next cycle with BYPASS=1, 0x00000000 with BYPASS=0; the following read gives 0xDEADBEEF in both.
- Write 0x12345678 to x0 (ZERO_REG=1) and claim x0, then read x0 -> rd = 0, rd_busy = 0, any_busy = 0.
- Claim x3 in cycle 1; read x3 in cycle 2 -> rd_busy = 1. Write 0xA5 to x3 in cycle 4 with a read of x3 -> rd = 0xA5 and rd_busy = 0; any_busy falls in cycle 5.
- Claim x9 and write x9 = 0x55 in the same cycle -> x9 reads 0x55 with rd_busy = 1. Then flush + claim x4 -> busy only on x4; any_busy = 1.
- Hold rd_en = 0 for 3 cycles while writing x2 = 0x77 -> rd unchanged. Assert reset mid-sequence -> all outputs 0 asynchronously, and x2 reads 0 afterwards.
